a_chk: RTL and testbench
========================

// Module: a_chk
// PURPOSE
//  Pass/fail judge downstream of a_fsm in the DFF setup/hold characterisation path.
//  For each data-delay code it collects N_TRIAL samples of DUT Q and compares each against the expected D.
//  If mismatches reach TH_FAIL, it reports that code as the pass->fail boundary.
//  Otherwise it requests the next code (o_step) until CODE_MAX is exhausted.
// PARAMETERS
//  N_TRIAL   8    samples taken per delay code (>=1)
//  TH_FAIL   4    mismatch count at/above which a code fails (1..N_TRIAL)
//  CODE_W    8    delay code width (matches o_dat_dly_sel of a_fsm)
//  CODE_MAX  255  last code swept; must be < 2**CODE_W
// PORTS
//  i_clk         in   1       clock
//  i_rstn        in   1       async reset, active-low
//  i_start       in   1       start sweep pulse; sampled in IDLE only
//  i_abort       in   1       synchronous abort to IDLE; highest priority after reset
//  i_mode        in   1       0=LH (Q 0->1), 1=HL (Q 1->0); latched on start
//  i_smp_valid   in   1       DUT was clocked; i_q/i_exp valid this cycle
//  i_q           in   1       DUT flop output
//  i_exp         in   1       expected Q (D_INV value driven by a_fsm)
//  o_busy        out  1       1 in any state except IDLE
//  o_step        out  1       1-cycle request to a_fsm: advance delay code by one
//  o_code        out  CODE_W  code currently under test
//  o_res_valid   out  1       result valid; held until accepted
//  i_res_ready   in   1       result consumer ready
//  o_res_found   out  1       1=failing code found, 0=sweep exhausted without fail
//  o_res_mode    out  1       latched i_mode of this result
//  o_res_code    out  CODE_W  failing code, or CODE_MAX if not found
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; trial/mismatch counters 0.
//  States: IDLE -> SAMPLE -> JUDGE -> {STEP -> SAMPLE | REPORT -> IDLE}.
//  IDLE: i_start=1 -> latch i_mode, o_code=0, clear counters, go to SAMPLE next cycle.
//  SAMPLE: each i_smp_valid: trial_cnt+=1; mis_cnt+=(i_q!=i_exp).
//    The sample bringing trial_cnt to N_TRIAL -> JUDGE next cycle.
//    i_smp_valid outside SAMPLE is ignored.
//  JUDGE (exactly 1 cycle):
//    mis_cnt>=TH_FAIL -> REPORT, found=1, res_code=o_code.
//    else o_code==CODE_MAX -> REPORT, found=0, res_code=CODE_MAX.
//    else -> STEP.
//  STEP (1 cycle): o_step=1; o_code+=1; counters cleared; -> SAMPLE.
//  REPORT: o_res_valid=1; o_res_* stable while valid && !ready.
//    valid&&ready -> IDLE next cycle, o_res_valid=0.
//  Handshake may complete in the first REPORT cycle.
//  i_start while busy is ignored. This includes the REPORT handshake cycle; a new start requires IDLE.
//  i_abort: -> IDLE next cycle, o_res_valid=0, counters cleared; o_code holds value.
//  i_rstn low mid-sweep: immediate return to reset values; no partial result emitted.
//  Counter widths: trial_cnt/mis_cnt = $clog2(N_TRIAL+1); no wrap is possible.
//  o_code never exceeds CODE_MAX.
//  Latency: last sample -> JUDGE +1 -> o_step or o_res_valid +2 cycles after the last sample.
// CONFIGURATION
//  A_CHK_SYNC_EN defined:
//    i_q passes through a 2-flop synchroniser.
//    i_smp_valid and i_exp are delayed 2 cycles to stay aligned.
//    Sample-to-count latency = 3 cycles.
//    The delay pipe is flushed by abort and reset.
//    Samples in flight at STEP are discarded: counters clear and the valid pipe is zeroed.
//  A_CHK_SYNC_EN undefined:
//    i_q is used directly.
//    Sample-to-count latency = 1 cycle.
// TESTING
//  1. Defaults; Q always matches exp -> 255 o_step pulses, then o_res_valid, found=0, code=255.
//  2. Mismatch forced from code 37 onward, all 8 trials -> found=1, code=37, exactly 37 o_step pulses.
//  3. Code 10 with exactly 3 mismatches, then 4 at code 11 -> no fail at 10; found=1, code=11.
//  4. i_res_ready low 5 cycles in REPORT -> o_res_* stable; ready=1 -> IDLE next cycle.
//     Same-cycle i_start is ignored.
//  5. i_abort mid-SAMPLE at code 20 -> IDLE next cycle, no result.
//     Restart -> o_code=0, counters 0.
//  6. i_rstn pulse mid-STEP -> all outputs 0.
//     With A_CHK_SYNC_EN: first count occurs 3 cycles after i_smp_valid.

Source files
------------

// File: rtl/a_chk.sv
// a_chk: pass/fail judge for the DFF setup/hold characterisation sweep.
// For every data-delay code it collects N_TRIAL samples of the DUT flop output,
// counts mismatches against the expected value and either requests the next
// code (o_step) or reports the first failing code / exhausted sweep.
// Build option: define A_CHK_SYNC_EN to pass i_q through a 2-flop synchroniser
// (i_smp_valid and i_exp are delayed to match, sample-to-count latency 3).
module a_chk #(
  parameter int N_TRIAL  = 8,
  parameter int TH_FAIL  = 4,
  parameter int CODE_W   = 8,
  parameter int CODE_MAX = 255
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_mode,
  input  logic              i_smp_valid,
  input  logic              i_q,
  input  logic              i_exp,
  output logic              o_busy,
  output logic              o_step,
  output logic [CODE_W-1:0] o_code,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic              o_res_found,
  output logic              o_res_mode,
  output logic [CODE_W-1:0] o_res_code
);

  localparam int CNT_W = $clog2(N_TRIAL + 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  TRIAL_PEN  = CNT_W'(N_TRIAL - 1);
  localparam logic [CNT_W-1:0]  TH_CNT     = CNT_W'(TH_FAIL);
  localparam logic [CODE_W-1:0] CODE_ZERO  = {CODE_W{1'b0}};
  localparam logic [CODE_W-1:0] CODE_ONE   = {{(CODE_W-1){1'b0}}, 1'b1};
  localparam logic [CODE_W-1:0] CODE_LAST  = CODE_W'(CODE_MAX);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_JUDGE  = 3'd2,
    ST_STEP   = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   trial_q, trial_d;
  logic [CNT_W-1:0]   mis_q, mis_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               mode_q, mode_d;
  logic               busy_q, busy_d;
  logic               step_q, step_d;
  logic               res_valid_q, res_valid_d;
  logic               res_found_q, res_found_d;
  logic               res_mode_q, res_mode_d;
  logic [CODE_W-1:0]  res_code_q, res_code_d;
  logic               smp_vld_s;
  logic               smp_mis_s;

`ifdef A_CHK_SYNC_EN
  logic [1:0] q_sync_q, q_sync_d;
  logic [1:0] exp_dly_q, exp_dly_d;
  logic [1:0] vld_dly_q, vld_dly_d;

  // Shift Q through the synchroniser with valid/exp delayed alongside; drop samples outside SAMPLE.
  always_comb begin
    q_sync_d  = {q_sync_q[0], i_q};
    exp_dly_d = {exp_dly_q[0], i_exp};
    vld_dly_d = {vld_dly_q[0], i_smp_valid};
    if (i_abort) begin
      q_sync_d  = 2'b00;
      exp_dly_d = 2'b00;
      vld_dly_d = 2'b00;
    end else if ((state_q == ST_STEP) || (state_q == ST_IDLE)) begin
      vld_dly_d = 2'b00;
    end else begin
      vld_dly_d = {vld_dly_q[0], i_smp_valid};
    end
  end

  // Synchroniser and alignment pipe registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      q_sync_q  <= 2'b00;
      exp_dly_q <= 2'b00;
      vld_dly_q <= 2'b00;
    end else begin
      q_sync_q  <= q_sync_d;
      exp_dly_q <= exp_dly_d;
      vld_dly_q <= vld_dly_d;
    end
  end

  assign smp_vld_s = vld_dly_q[1];
  assign smp_mis_s = q_sync_q[1] ^ exp_dly_q[1];
`else
  assign smp_vld_s = i_smp_valid;
  assign smp_mis_s = i_q ^ i_exp;
`endif

  // Next-state, counters, code and result capture; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    trial_d     = trial_q;
    mis_d       = mis_q;
    code_d      = code_q;
    mode_d      = mode_q;
    res_valid_d = res_valid_q;
    res_found_d = res_found_q;
    res_mode_d  = res_mode_q;
    res_code_d  = res_code_q;
    if (i_abort) begin
      state_d     = ST_IDLE;
      trial_d     = CNT_ZERO;
      mis_d       = CNT_ZERO;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d = ST_SAMPLE;
            mode_d  = i_mode;
            code_d  = CODE_ZERO;
            trial_d = CNT_ZERO;
            mis_d   = CNT_ZERO;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SAMPLE: begin
          if (smp_vld_s) begin
            trial_d = trial_q + CNT_ONE;
            mis_d   = mis_q + {{(CNT_W-1){1'b0}}, smp_mis_s};
            if (trial_q == TRIAL_PEN) begin
              state_d = ST_JUDGE;
            end else begin
              state_d = ST_SAMPLE;
            end
          end else begin
            state_d = ST_SAMPLE;
          end
        end
        ST_JUDGE: begin
          if (mis_q >= TH_CNT) begin
            state_d     = ST_REPORT;
            res_valid_d = 1'b1;
            res_found_d = 1'b1;
            res_mode_d  = mode_q;
            res_code_d  = code_q;
          end else if (code_q == CODE_LAST) begin
            state_d     = ST_REPORT;
            res_valid_d = 1'b1;
            res_found_d = 1'b0;
            res_mode_d  = mode_q;
            res_code_d  = CODE_LAST;
          end else begin
            state_d = ST_STEP;
          end
        end
        ST_STEP: begin
          state_d = ST_SAMPLE;
          code_d  = code_q + CODE_ONE;
          trial_d = CNT_ZERO;
          mis_d   = CNT_ZERO;
        end
        ST_REPORT: begin
          if (i_res_ready) begin
            state_d     = ST_IDLE;
            res_valid_d = 1'b0;
          end else begin
            state_d = ST_REPORT;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          trial_d     = CNT_ZERO;
          mis_d       = CNT_ZERO;
          res_valid_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
    step_d = (state_d == ST_STEP);
  end

  // State, counter and registered-output flops.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      trial_q     <= CNT_ZERO;
      mis_q       <= CNT_ZERO;
      code_q      <= CODE_ZERO;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      step_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_found_q <= 1'b0;
      res_mode_q  <= 1'b0;
      res_code_q  <= CODE_ZERO;
    end else begin
      state_q     <= state_d;
      trial_q     <= trial_d;
      mis_q       <= mis_d;
      code_q      <= code_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      step_q      <= step_d;
      res_valid_q <= res_valid_d;
      res_found_q <= res_found_d;
      res_mode_q  <= res_mode_d;
      res_code_q  <= res_code_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_step      = step_q;
  assign o_code      = code_q;
  assign o_res_valid = res_valid_q;
  assign o_res_found = res_found_q;
  assign o_res_mode  = res_mode_q;
  assign o_res_code  = res_code_q;

endmodule

// File: tb/tb_a_chk.sv
// Self-checking bench for a_chk: emulates a_fsm (answers o_step with a fresh
// batch of samples), plans the mismatch count per code, and predicts the sweep
// outcome from the plan alone (first code whose mismatches reach TH_FAIL).
module tb_a_chk;
  localparam int N_TRIAL  = 8;
  localparam int TH_FAIL  = 4;
  localparam int CODE_W   = 8;
  localparam int CODE_MAX = 255;
`ifdef A_CHK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic              i_clk, i_rstn, i_start, i_abort, i_mode;
  logic              i_smp_valid, i_q, i_exp, i_res_ready;
  logic              o_busy, o_step, o_res_valid, o_res_found, o_res_mode;
  logic [CODE_W-1:0] o_code, o_res_code;

  int n_vec = 0;
  int n_mis = 0;
  int step_total = 0;
  int plan [0:CODE_MAX];

  a_chk #(.N_TRIAL(N_TRIAL), .TH_FAIL(TH_FAIL), .CODE_W(CODE_W), .CODE_MAX(CODE_MAX)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_abort(i_abort),
    .i_mode(i_mode), .i_smp_valid(i_smp_valid), .i_q(i_q), .i_exp(i_exp),
    .o_busy(o_busy), .o_step(o_step), .o_code(o_code), .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready), .o_res_found(o_res_found), .o_res_mode(o_res_mode),
    .o_res_code(o_res_code)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Count every o_step pulse seen at the falling edge.
  always @(negedge i_clk) if (o_step === 1'b1) step_total++;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present N_TRIAL valid samples, nmis of them mismatching, with random gaps.
  task automatic send_code(input int nmis);
    int  left;
    bit  mism;
    left = nmis;
    for (int t = 0; t < N_TRIAL; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        i_smp_valid = 1'b0;
        i_q   = 1'($urandom);
        i_exp = 1'($urandom);
        tick();
      end
      mism = (left > 0) && (((N_TRIAL - t) <= left) || ($urandom_range(0, 1) == 1));
      if (mism) left--;
      i_smp_valid = 1'b1;
      i_exp = 1'($urandom);
      i_q   = i_exp ^ mism;
      tick();
    end
    i_smp_valid = 1'b0;
  endtask

  // Wait (bounded) for o_step (kind 1) or o_res_valid (kind 2); 0 on timeout.
  task automatic wait_event(output int kind);
    int w;
    kind = 0;
    for (w = 1; w <= 12; w++) begin
      tick();
      if (o_step === 1'b1 || o_res_valid === 1'b1) break;
    end
    if (o_step === 1'b1 && o_res_valid !== 1'b1) kind = 1;
    else if (o_res_valid === 1'b1 && o_step !== 1'b1) kind = 2;
    else kind = 0;
    if (kind != 0) chk_eq("judge_latency", 32'(w), 32'(LAT));
  endtask

  task automatic start_sweep(input bit mode);
    i_mode  = mode;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_mode  = 1'($urandom);
    chk_eq("start_busy", 32'(o_busy), 32'd1);
    chk_eq("start_code", 32'(o_code), 32'd0);
  endtask

  // Full sweep against the plan; hold = cycles with ready low in REPORT.
  task automatic run_sweep(input bit mode, input int hold);
    bit exp_found;
    int exp_code, kind, s0;
    exp_found = 1'b0;
    exp_code  = CODE_MAX;
    for (int c = 0; c <= CODE_MAX; c++)
      if (!exp_found && plan[c] >= TH_FAIL) begin
        exp_found = 1'b1;
        exp_code  = c;
      end
    s0 = step_total;
    start_sweep(mode);
    for (int c = 0; c <= CODE_MAX; c++) begin
      chk_eq("code_under_test", 32'(o_code), 32'(c));
      chk_eq("busy_in_sweep", 32'(o_busy), 32'd1);
      send_code(plan[c]);
      wait_event(kind);
      chk_eq("event_kind", 32'(kind), (c == exp_code) ? 32'd2 : 32'd1);
      if (kind != ((c == exp_code) ? 2 : 1)) return;
      if (kind == 2) break;
      tick();
      chk_eq("step_width", 32'(o_step), 32'd0);
    end
    chk_eq("res_found", 32'(o_res_found), 32'(exp_found));
    chk_eq("res_code", 32'(o_res_code), 32'(exp_code));
    chk_eq("res_mode", 32'(o_res_mode), 32'(mode));
    chk_eq("step_count", 32'(step_total - s0), 32'(exp_code));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk_eq("hold_valid", 32'(o_res_valid), 32'd1);
      chk_eq("hold_code", 32'(o_res_code), 32'(exp_code));
      chk_eq("hold_found", 32'(o_res_found), 32'(exp_found));
      chk_eq("hold_mode", 32'(o_res_mode), 32'(mode));
    end
    i_res_ready = 1'b1;
    i_start     = 1'b1;
    tick();
    i_res_ready = 1'b0;
    i_start     = 1'b0;
    chk_eq("ack_valid_low", 32'(o_res_valid), 32'd0);
    chk_eq("ack_idle", 32'(o_busy), 32'd0);
    tick();
    chk_eq("start_in_ack_ignored", 32'(o_busy), 32'd0);
  endtask

  task automatic plan_fill(input int lo, input int hi);
    for (int c = 0; c <= CODE_MAX; c++) plan[c] = $urandom_range(hi, lo);
  endtask

  initial begin
    int kind, k;
    i_rstn = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_mode = 1'b0;
    i_smp_valid = 1'b0; i_q = 1'b0; i_exp = 1'b0; i_res_ready = 1'b0;
    repeat (3) tick();
    chk_eq("rst_busy", 32'(o_busy), 32'd0);
    chk_eq("rst_step", 32'(o_step), 32'd0);
    chk_eq("rst_code", 32'(o_code), 32'd0);
    chk_eq("rst_valid", 32'(o_res_valid), 32'd0);
    chk_eq("rst_found", 32'(o_res_found), 32'd0);
    chk_eq("rst_mode", 32'(o_res_mode), 32'd0);
    chk_eq("rst_rcode", 32'(o_res_code), 32'd0);
    @(negedge i_clk) i_rstn = 1'b1;
    tick();

    // Clean sweep: never fails, exhausts at CODE_MAX.
    plan_fill(0, 0);
    run_sweep(1'b0, 2);

    // Hard failure from code 37 onward.
    plan_fill(0, 0);
    for (int c = 37; c <= CODE_MAX; c++) plan[c] = 8;
    run_sweep(1'b1, 0);

    // Threshold edge: 3 mismatches pass at 10, 4 fail at 11; ready held low 5 cycles.
    plan_fill(0, 3);
    plan[10] = 3;
    plan[11] = 4;
    run_sweep(1'b0, 5);

    // Random sweeps.
    for (int r = 0; r < 2; r++) begin
      plan_fill(0, 3);
      k = $urandom_range(0, 60);
      plan[k] = $urandom_range(TH_FAIL, N_TRIAL);
      for (int c = k + 1; c <= CODE_MAX; c++) plan[c] = $urandom_range(0, N_TRIAL);
      run_sweep(1'($urandom), $urandom_range(0, 4));
    end

    // Abort mid-SAMPLE at code 20 after three mismatching samples.
    start_sweep(1'b0);
    for (int c = 0; c < 20; c++) begin
      send_code(0);
      wait_event(kind);
      chk_eq("abort_pre_step", 32'(kind), 32'd1);
      tick();
    end
    chk_eq("abort_code20", 32'(o_code), 32'd20);
    for (int t = 0; t < 3; t++) begin
      i_smp_valid = 1'b1;
      i_exp = 1'($urandom);
      i_q   = ~i_exp;
      tick();
    end
    i_smp_valid = 1'b0;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk_eq("abort_busy", 32'(o_busy), 32'd0);
    chk_eq("abort_valid", 32'(o_res_valid), 32'd0);
    chk_eq("abort_code_hold", 32'(o_code), 32'd20);
    for (int t = 0; t < 4; t++) begin
      tick();
      chk_eq("abort_no_result", 32'(o_res_valid), 32'd0);
    end
    // Restart: stale counts from the aborted code would fail code 0.
    plan_fill(0, 0);
    plan[0] = 3;
    plan[1] = 4;
    run_sweep(1'b1, 1);

    // Asynchronous reset pulse during STEP.
    plan_fill(0, 0);
    start_sweep(1'b1);
    send_code(0);
    wait_event(kind);
    chk_eq("rst_mid_step_kind", 32'(kind), 32'd1);
    #2 i_rstn = 1'b0;
    #1;
    chk_eq("arst_busy", 32'(o_busy), 32'd0);
    chk_eq("arst_step", 32'(o_step), 32'd0);
    chk_eq("arst_code", 32'(o_code), 32'd0);
    chk_eq("arst_valid", 32'(o_res_valid), 32'd0);
    @(negedge i_clk) i_rstn = 1'b1;
    tick();
    chk_eq("arst_idle", 32'(o_busy), 32'd0);
    chk_eq("arst_no_result", 32'(o_res_valid), 32'd0);
    plan[0] = 8;
    run_sweep(1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
